// File: rtl/clock_monitor.sv
// clock_monitor
//   Measures the half-period of an asynchronous monitored clock in units of
//   the reference clock and reports whether it is stable.
//   Each edge of mon_clk is synchronized and then strobed. The time between
//   edges is counted. A four-state FSM (IDLE/ACQUIRE/LOCKED/LOST) declares
//   lock after LOCK_CYCLES consecutive in-tolerance half-periods. It declares
//   loss when no edge arrives within TIMEOUT reference cycles.
//
// Ports
//   clk_in       : reference clock; all logic runs on its rising edge
//   rst          : synchronous active-high reset
//   mon_clk      : monitored clock; may be asynchronous to clk_in
//   rise_pulse   : one-cycle strobe per synchronized rising edge of mon_clk
//   fall_pulse   : one-cycle strobe per synchronized falling edge of mon_clk
//   half_period  : last measured edge-to-edge interval, in clk_in cycles
//   period_valid : one-cycle strobe when half_period updates
//   locked       : FSM is in LOCKED
//   lost         : FSM is in LOST
//   err_count    : saturating count of out-of-tolerance measurements
module clock_monitor #(
  parameter int  CLK_IN      = 100,
  parameter int  CLK_OUT     = 10,
  parameter int  TOL         = 1,
  parameter int  LOCK_CYCLES = 4,
  parameter int  SYNC_STAGES = 2,
  localparam int HALF        = (CLK_IN / CLK_OUT) / 2,
  localparam int TIMEOUT     = 2 * HALF + TOL,
  localparam int W           = $clog2(TIMEOUT + 1)
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic         mon_clk,
  output logic         rise_pulse,
  output logic         fall_pulse,
  output logic [W-1:0] half_period,
  output logic         period_valid,
  output logic         locked,
  output logic         lost,
  output logic [7:0]   err_count
);

  localparam int              GW      = $clog2(LOCK_CYCLES + 1);
  localparam logic [W-1:0]    CNT_MAX = W'(TIMEOUT);
  localparam logic [W-1:0]    GOOD_LO = W'(HALF - TOL);
  localparam logic [W-1:0]    GOOD_HI = W'(HALF + TOL);
  localparam logic [GW-1:0]   LOCK_N  = GW'(LOCK_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACQUIRE,
    ST_LOCKED,
    ST_LOST
  } state_t;

  function automatic logic [W-1:0] sat_inc_cnt(input logic [W-1:0] v);
    return (v == CNT_MAX) ? v : v + W'(1);
  endfunction

  function automatic logic [7:0] sat_inc_err(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [SYNC_STAGES-1:0] sync;
  logic                   hist;
  logic [W-1:0]           cnt;
  logic [GW-1:0]          good_q, good_d;
  state_t                 state_q, state_d;

  logic edge_det;
  logic has_ref;
  logic meas;
  logic meas_good;
  logic timeout;

  assign edge_det  = sync[SYNC_STAGES-1] ^ hist;
  // A measurement needs a reference edge already taken in this acquisition.
  assign has_ref   = (state_q == ST_ACQUIRE) || (state_q == ST_LOCKED);
  assign meas      = edge_det && has_ref;
  assign meas_good = (cnt >= GOOD_LO) && (cnt <= GOOD_HI);
  // An edge arriving in the same cycle as the timeout wins.
  assign timeout   = (cnt == CNT_MAX) && !edge_det;

  assign locked = (state_q == ST_LOCKED);
  assign lost   = (state_q == ST_LOST);

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    case (state_q)
      ST_IDLE: begin
        if (edge_det) begin
          state_d = ST_ACQUIRE;
          good_d  = '0;
        end else if (timeout) begin
          state_d = ST_LOST;
        end
      end
      ST_ACQUIRE: begin
        if (meas) begin
          if (meas_good) begin
            good_d = good_q + GW'(1);
            if (good_q + GW'(1) == LOCK_N) state_d = ST_LOCKED;
          end else begin
            good_d = '0;
          end
        end else if (timeout) begin
          state_d = ST_LOST;
        end
      end
      ST_LOCKED: begin
        if (meas && !meas_good) begin
          state_d = ST_ACQUIRE;
          good_d  = '0;
        end else if (timeout) begin
          state_d = ST_LOST;
        end
      end
      ST_LOST: begin
        // The recovering edge only re-establishes the reference.
        if (edge_det) begin
          state_d = ST_ACQUIRE;
          good_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync         <= '0;
      hist         <= 1'b0;
      cnt          <= '0;
      state_q      <= ST_IDLE;
      good_q       <= '0;
      rise_pulse   <= 1'b0;
      fall_pulse   <= 1'b0;
      period_valid <= 1'b0;
      half_period  <= '0;
      err_count    <= '0;
    end else begin
      // Stage: synchronizer chain and edge history
      sync <= {sync[SYNC_STAGES-2:0], mon_clk};
      hist <= sync[SYNC_STAGES-1];
      // Stage: interval counter, FSM and registered outputs
      cnt          <= edge_det ? W'(1) : sat_inc_cnt(cnt);
      state_q      <= state_d;
      good_q       <= good_d;
      rise_pulse   <= edge_det &&  sync[SYNC_STAGES-1];
      fall_pulse   <= edge_det && !sync[SYNC_STAGES-1];
      period_valid <= meas;
      if (meas) half_period <= cnt;
      if (meas && !meas_good) err_count <= sat_inc_err(err_count);
    end
  end

endmodule

// File: tb/tb_clock_monitor.sv
// Self-checking bench for clock_monitor with default parameters.
// A cycle-level reference model derives edges from the sampled mon_clk
// history. It measures intervals as differences of edge times, and applies the
// lock/loss rules with plain integer bookkeeping.
module tb_clock_monitor;
  localparam int CLK_IN      = 100;
  localparam int CLK_OUT     = 10;
  localparam int TOL         = 1;
  localparam int LOCK_CYCLES = 4;
  localparam int SYNC_STAGES = 2;
  localparam int HALF        = (CLK_IN / CLK_OUT) / 2;
  localparam int TIMEOUT     = 2 * HALF + TOL;
  localparam int W           = $clog2(TIMEOUT + 1);

  localparam int S_IDLE = 0, S_ACQ = 1, S_LOCKED = 2, S_LOST = 3;

  logic         clk_in  = 1'b0;
  logic         rst     = 1'b1;
  logic         mon_clk = 1'b0;
  logic         rise_pulse, fall_pulse, period_valid, locked, lost;
  logic [W-1:0] half_period;
  logic [7:0]   err_count;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk_in = ~clk_in;

  clock_monitor #(
    .CLK_IN(CLK_IN), .CLK_OUT(CLK_OUT), .TOL(TOL),
    .LOCK_CYCLES(LOCK_CYCLES), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk_in(clk_in), .rst(rst), .mon_clk(mon_clk),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .half_period(half_period), .period_valid(period_valid),
    .locked(locked), .lost(lost), .err_count(err_count)
  );

  logic [16:0] outs;
  assign outs = {rise_pulse, fall_pulse, period_valid, locked, lost, half_period, err_count};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  bit          e [0:65535];
  int          t = SYNC_STAGES + 1;
  int          st, g, ref_t, m_half, m_err, d;
  bit          m_rise, m_fall, m_pv, ev, good;
  logic [16:0] exp_v;

  always @(posedge clk_in) begin
    t++;
    if (rst) begin
      for (int k = 0; k <= SYNC_STAGES; k++) e[t-k] = 1'b0;
      st = S_IDLE; g = 0; ref_t = t + 1;
      m_half = 0; m_err = 0; m_rise = 0; m_fall = 0; m_pv = 0;
    end else begin
      e[t]   = mon_clk;
      ev     = (e[t-SYNC_STAGES] != e[t-SYNC_STAGES-1]);
      m_rise = ev &&  e[t-SYNC_STAGES];
      m_fall = ev && !e[t-SYNC_STAGES];
      m_pv   = 1'b0;
      if (ev) begin
        if (st == S_IDLE || st == S_LOST) begin
          st = S_ACQ; g = 0;
        end else begin
          d      = t - ref_t;
          m_half = d;
          m_pv   = 1'b1;
          good   = (d >= HALF - TOL) && (d <= HALF + TOL);
          if (!good && m_err < 255) m_err++;
          if (st == S_ACQ) begin
            if (good) begin
              g++;
              if (g == LOCK_CYCLES) st = S_LOCKED;
            end else g = 0;
          end else if (!good) begin
            st = S_ACQ; g = 0;
          end
        end
        ref_t = t;
      end else if (st != S_LOST && t - ref_t >= TIMEOUT) begin
        st = S_LOST;
      end
    end
    exp_v = {m_rise, m_fall, m_pv, st == S_LOCKED, st == S_LOST, W'(m_half), 8'(m_err)};
    #1;
    check("cycle", 32'(outs), 32'(exp_v));
  end

  task automatic half(input int n);
    @(negedge clk_in) mon_clk = ~mon_clk;
    repeat (n - 1) @(negedge clk_in);
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic pulse_rst();
    @(negedge clk_in) rst = 1'b1;
    @(posedge clk_in);
    #2;
    check("rst_clear", 32'(outs), 32'(0));
    @(negedge clk_in) rst = 1'b0;
  endtask

  int n;

  initial begin
    rst = 1'b1;
    hold(3);
    rst = 1'b0;
    check("reset_state", 32'(outs), 32'(0));

    // No edges after reset: loss detected from IDLE, no measurement
    hold(16);
    check("idle_lost", 32'(lost), 32'(1));
    check("idle_half", 32'(half_period), 32'(0));

    // Steady half-period of HALF
    repeat (8) half(5);
    check("lock_a", 32'(locked), 32'(1));
    check("half_a", 32'(half_period), 32'(5));
    check("err_a", 32'(err_count), 32'(0));

    // 4 and 6 are within tolerance
    half(4); half(6); half(5);
    check("lock_tol", 32'(locked), 32'(1));
    check("err_tol", 32'(err_count), 32'(0));

    // 7 is out of tolerance
    half(7); half(5);
    check("drop_7", 32'(locked), 32'(0));
    check("err_7", 32'(err_count), 32'(1));
    check("half_7", 32'(half_period), 32'(7));
    repeat (4) half(5);
    check("relock_7", 32'(locked), 32'(1));

    // 3 is out of tolerance
    half(3); half(5);
    check("drop_3", 32'(locked), 32'(0));
    check("err_3", 32'(err_count), 32'(2));
    repeat (5) half(5);
    check("relock_3", 32'(locked), 32'(1));

    // Frozen monitored clock
    half(20);
    check("frozen_lost", 32'(lost), 32'(1));
    check("frozen_lock", 32'(locked), 32'(0));
    repeat (7) half(5);
    check("restart_lock", 32'(locked), 32'(1));
    check("restart_lost", 32'(lost), 32'(0));

    // Reset while locked, with mon_clk low so no edge is seen afterwards
    if (mon_clk) half(5);
    pulse_rst();
    repeat (7) half(5);
    check("fresh_lock", 32'(locked), 32'(1));
    check("fresh_err", 32'(err_count), 32'(0));

    // Error counter saturation
    repeat (300) half(9);
    check("err_sat", 32'(err_count), 32'(255));
    check("half_9", 32'(half_period), 32'(9));

    // Randomized mix of half-periods, timeouts and resets
    repeat (200) begin
      if ($urandom_range(0, 24) == 0) pulse_rst();
      else begin
        if ($urandom_range(0, 3) == 0) n = $urandom_range(2, 14);
        else n = $urandom_range(4, 6);
        half(n);
      end
    end
    hold(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_monitor.md
CLOCK_MONITOR -- requirements
Module: clock_monitor

Interface
REQ-001 SHALL provide parameter CLK_IN, default 100, meaning reference clk_in frequency.
REQ-002 SHALL provide parameter CLK_OUT, default 10, meaning expected frequency of mon_clk.
REQ-003 SHALL provide parameter TOL, default 1, meaning allowed half-period deviation in clk_in cycles.
REQ-004 SHALL provide parameter LOCK_CYCLES, default 4, meaning consecutive good half-periods required to lock.
REQ-005 SHALL provide parameter SYNC_STAGES, default 2, meaning synchronizer depth.
REQ-006 SHALL define derived constants HALF=(CLK_IN/CLK_OUT)/2, TIMEOUT=2*HALF+TOL and W=$clog2(TIMEOUT+1); legal values are HALF>=2, TOL<HALF, LOCK_CYCLES>=1 and SYNC_STAGES>=2.
REQ-007 SHALL have port clk_in, input, 1 bit, sole clock; all logic clocks on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit, reset; it is synchronous and active-high.
REQ-009 SHALL have port mon_clk, input, 1 bit, monitored clock, which may be asynchronous to clk_in (typically a divided clock).
REQ-010 SHALL have port rise_pulse, output, 1 bit, one-cycle strobe on each synchronized rising edge of mon_clk.
REQ-011 SHALL have port fall_pulse, output, 1 bit, one-cycle strobe on each synchronized falling edge of mon_clk.
REQ-012 SHALL have port half_period, output, W bits, the last measured interval between edges, in clk_in cycles.
REQ-013 SHALL have port period_valid, output, 1 bit, one-cycle strobe when half_period updates.
REQ-014 SHALL have port locked, output, 1 bit, high while the FSM is in LOCKED.
REQ-015 SHALL have port lost, output, 1 bit, high while the FSM is in LOST.
REQ-016 SHALL have port err_count, output, 8 bits, saturating count of out-of-tolerance measurements.

Function
REQ-017 SHALL synchronize mon_clk through SYNC_STAGES flops, then one history flop; the edge strobe is the XOR of the last stage and the history flop.
REQ-018 SHALL register rise_pulse/fall_pulse so each is high exactly one cycle, SYNC_STAGES+1 clk_in edges after the first edge that samples the new mon_clk level.
REQ-019 SHALL keep interval counter cnt: on an edge strobe, cnt<=1; otherwise cnt<=cnt+1, saturating at TIMEOUT; a steady clock of half-period HALF therefore measures exactly HALF.
REQ-020 SHALL, on an edge strobe that has a prior reference edge, load half_period<=cnt and pulse period_valid in the same cycle as rise_pulse/fall_pulse.
REQ-021 SHALL produce no measurement and no period_valid on the first edge after reset or after leaving LOST.
REQ-022 SHALL classify a measurement as good iff |half_period-HALF|<=TOL, and as bad otherwise.
REQ-023 SHALL implement FSM states IDLE (reset state, no reference edge), ACQUIRE, LOCKED and LOST, with good_cnt tracking consecutive good measurements.
REQ-024 SHALL move from IDLE to ACQUIRE with good_cnt=0 on the first edge, and from IDLE to LOST on timeout.
REQ-025 SHALL, in ACQUIRE: increment good_cnt on a good measurement and enter LOCKED when good_cnt reaches LOCK_CYCLES; clear good_cnt on a bad measurement; enter LOST on timeout.
REQ-026 SHALL, in LOCKED: enter ACQUIRE with good_cnt=0 on a bad measurement; enter LOST on timeout.
REQ-027 SHALL, in LOST, enter ACQUIRE with good_cnt=0 on the next edge; that edge is reference only.
REQ-028 SHALL define timeout as cnt==TIMEOUT with no edge strobe that cycle; when an edge and the timeout coincide, the edge wins.
REQ-029 SHALL increment err_count on every bad measurement in any state, saturating at 255.
REQ-030 SHALL drive locked and lost directly from registered state, with no combinational paths from mon_clk to any output.

Reset
REQ-031 SHALL, when rst is sampled high, clear in the next cycle: the synchronizer, history flop, cnt, good_cnt, rise_pulse, fall_pulse, period_valid, locked, lost, half_period and err_count to 0, with FSM=IDLE.
REQ-032 SHALL give rst priority over every other event, including an assertion mid-LOCKED or mid-measurement.

Verification (CLK_IN=100, CLK_OUT=10 -> HALF=5, TOL=1, TIMEOUT=11, LOCK_CYCLES=4, SYNC_STAGES=2)
REQ-033 SHALL cover: mon_clk toggling every 5 clk_in cycles -> period_valid every 5 cycles, half_period=5, locked high after the 4th measurement, err_count=0.
REQ-034 SHALL cover: half-periods of 4, 6, 7 and 3 while locked -> 4 and 6 keep locked; 7 and 3 each drop to ACQUIRE and increment err_count; relock after 4 good measurements.
REQ-035 SHALL cover: mon_clk frozen while locked -> lost high when cnt reaches 11, locked low; on restart the first edge gives no period_valid, and lock returns after 4 good measurements.
REQ-036 SHALL cover: no mon_clk edges after reset -> lost asserts at cnt==11 while in IDLE, and half_period stays 0.
REQ-037 SHALL cover: rst pulsed for one cycle mid-LOCKED -> all outputs 0 on the next cycle, FSM=IDLE, and a fresh lock after 4 good measurements.
REQ-038 SHALL cover: 300 consecutive bad half-periods (value 9) -> err_count stops at 255 and never wraps.
